// File: rtl/pattern_tx_pkg.sv
// Shared types and defaults for the pattern_tx serial strobe transmitter.
package pattern_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    GAP
  } state_t;

  localparam int unsigned PTX_TRIG_CYCLES = 2;
  localparam int unsigned PTX_GAP_CYCLES  = 5;

  // Width of a field holding a bit count 0..w.
  function automatic int unsigned len_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/strobe_timer.sv
// Loadable down-counter that parks at zero; reloaded once per strobe/gap phase.
module strobe_timer #(
  parameter int unsigned TW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [TW-1:0] load_value,
  output logic          zero
);

  logic [TW-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: sends a loaded word MSB-first as data/trig bit strobes.
module pattern_tx
  import pattern_tx_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned TRIG_CYCLES = PTX_TRIG_CYCLES,
  parameter int unsigned GAP_CYCLES  = PTX_GAP_CYCLES
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load_valid,
  output logic                        load_ready,
  input  logic [WIDTH-1:0]            load_data,
  input  logic [len_width(WIDTH)-1:0] load_len,
  output logic                        data,
  output logic                        trig,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned LW   = len_width(WIDTH);
  localparam int unsigned TMAX = (TRIG_CYCLES > GAP_CYCLES) ? TRIG_CYCLES : GAP_CYCLES;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [LW-1:0]    cnt, cnt_n;
  logic             data_n, trig_n, done_n;
  logic             t_load, t_zero;
  logic [TW-1:0]    t_value;
  logic [LW-1:0]    len_c, shift;
  logic [WIDTH-1:0] aligned;

  strobe_timer #(.TW(TW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (t_load),
    .load_value (t_value),
    .zero       (t_zero)
  );

  // Frame is left-justified so the first bit to send always sits at the MSB.
  assign len_c   = (load_len > LW'(WIDTH)) ? LW'(WIDTH) : load_len;
  assign shift   = LW'(WIDTH) - len_c;
  assign aligned = load_data << shift;

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = cnt;
    data_n  = data;
    trig_n  = trig;
    done_n  = 1'b0;
    t_load  = 1'b0;
    t_value = '0;
    case (state)
      IDLE: begin
        trig_n = 1'b0;
        data_n = 1'b0;
        if (load_valid && load_ready) begin
          if (len_c != '0) begin
            state_n = STROBE;
            data_n  = aligned[WIDTH-1];
            shreg_n = aligned << 1;
            cnt_n   = len_c - 1'b1;
            trig_n  = 1'b1;
            t_load  = 1'b1;
            t_value = TW'(TRIG_CYCLES - 1);
          end else begin
            done_n = 1'b1;
          end
        end
      end
      STROBE: begin
        if (t_zero) begin
          state_n = GAP;
          trig_n  = 1'b0;
          t_load  = 1'b1;
          t_value = TW'(GAP_CYCLES - 1);
        end
      end
      GAP: begin
        if (t_zero) begin
          if (cnt == '0) begin
            state_n = IDLE;
            data_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            state_n = STROBE;
            data_n  = shreg[WIDTH-1];
            shreg_n = shreg << 1;
            cnt_n   = cnt - 1'b1;
            trig_n  = 1'b1;
            t_load  = 1'b1;
            t_value = TW'(TRIG_CYCLES - 1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // load_ready is a register so it stays low throughout reset, not only after it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      data       <= 1'b0;
      trig       <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      load_ready <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      cnt        <= cnt_n;
      data       <= data_n;
      trig       <= trig_n;
      done       <= done_n;
      busy       <= (state_n != IDLE);
      load_ready <= (state_n == IDLE);
    end
  end

endmodule

// File: tb/tb_pattern_tx.sv
// Self-checking bench for pattern_tx: directed and random frames against a cycle-offset timing model.
module tb_pattern_tx;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned TRIG  = 2;
  localparam int unsigned GAPC  = 5;
  localparam int unsigned P     = TRIG + GAPC;

  logic             clk = 1'b0;
  logic             reset;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic [3:0]       load_len;
  logic             data, trig, busy, done;

  int unsigned errors = 0;
  int unsigned checks = 0;

  pattern_tx #(
    .WIDTH       (WIDTH),
    .TRIG_CYCLES (TRIG),
    .GAP_CYCLES  (GAPC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_len   (load_len),
    .data       (data),
    .trig       (trig),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag, input logic rdy);
    chk({tag, ".data"},  data,  1'b0);
    chk({tag, ".trig"},  trig,  1'b0);
    chk({tag, ".busy"},  busy,  1'b0);
    chk({tag, ".done"},  done,  1'b0);
    chk({tag, ".ready"}, load_ready, rdy);
  endtask

  // Offer frame (d, len) in the current cycle (cycle 0) and check cycles 1..P*L+1
  // against the frame timing rules. stop_at>0 ends the check early at that cycle.
  // With hold, the next frame (nd, nlen) stays offered so it is accepted in the done cycle.
  task automatic send(input string tag, input logic [WIDTH-1:0] d, input int unsigned len,
                      input bit hold, input logic [WIDTH-1:0] nd, input int unsigned nlen,
                      input int unsigned stop_at);
    int unsigned lc;
    int unsigned last;
    lc = (len > WIDTH) ? WIDTH : len;
    last = P * lc + 1;
    if (stop_at != 0) last = stop_at;
    chk($sformatf("%s.c0.ready", tag), load_ready, 1'b1);
    load_valid = 1'b1;
    load_data  = d;
    load_len   = 4'(len);
    step();
    if (hold) begin
      load_data = nd;
      load_len  = 4'(nlen);
    end else begin
      load_valid = 1'b0;
      load_data  = WIDTH'($urandom);
      load_len   = 4'($urandom);
    end
    for (int unsigned c = 1; c <= last; c++) begin
      int unsigned k, ph;
      logic        b_e, t_e, d_e, dn_e;
      k    = (c - 1) / P;
      ph   = (c - 1) % P;
      b_e  = (c <= P * lc);
      t_e  = b_e && (ph < TRIG);
      d_e  = b_e ? d[lc-1-k] : 1'b0;
      dn_e = (c == P * lc + 1);
      chk($sformatf("%s.c%0d.busy", tag, c),  busy,       b_e);
      chk($sformatf("%s.c%0d.trig", tag, c),  trig,       t_e);
      chk($sformatf("%s.c%0d.data", tag, c),  data,       d_e);
      chk($sformatf("%s.c%0d.done", tag, c),  done,       dn_e);
      chk($sformatf("%s.c%0d.ready", tag, c), load_ready, !b_e);
      if (c != last) step();
    end
  endtask

  task automatic idle(input string tag, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      step();
      chk_quiet($sformatf("%s.i%0d", tag, i), 1'b1);
    end
  endtask

  initial begin
    reset      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    load_len   = '0;

    // Reset held: everything low, including load_ready.
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      chk_quiet($sformatf("rst%0d", i), 1'b0);
    end
    reset = 1'b1;
    step();
    chk("rel.ready", load_ready, 1'b1);
    idle("idle", 20);

    send("full", 8'b1011_0010, 8, 1'b0, '0, 0, 0);
    idle("after_full", 2);

    send("len0", 8'hA5, 0, 1'b0, '0, 0, 0);
    idle("after_len0", 2);

    send("len10", 8'b0110_1101, 10, 1'b0, '0, 0, 0);
    idle("after_len10", 1);

    // Back-to-back: second accept lands in the done cycle of the first.
    send("b2b_a", 8'b1111_1101, 3, 1'b1, 8'b0000_0010, 3, 0);
    send("b2b_b", 8'b0000_0010, 3, 1'b0, '0, 0, 0);
    idle("after_b2b", 2);

    // Reset in cycle 10 of an 8-bit frame.
    send("mid", 8'b1100_1011, 8, 1'b0, '0, 0, 10);
    reset = 1'b0;
    step();
    chk_quiet("midrst", 1'b0);
    reset = 1'b1;
    step();
    chk_quiet("midrel", 1'b1);
    idle("mididle", 60);
    send("post", 8'b1001_0110, 8, 1'b0, '0, 0, 0);

    // Random frames, lengths spanning 0..15 to exercise clamping.
    for (int unsigned f = 0; f < 10; f++) begin
      logic [WIDTH-1:0] rd;
      int unsigned      rl;
      rd = WIDTH'($urandom);
      rl = $urandom_range(15, 0);
      send($sformatf("rnd%0d", f), rd, rl, 1'b0, '0, 0, 0);
      idle($sformatf("rnd%0d_gap", f), $urandom_range(3, 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
